// File: rtl/flag_unit.sv
// flag_unit: NZCV condition-flag register with long-multiply (LO/HI) Z tracking,
// a combinational forward of the next flag value, and sequence-error reporting.
`default_nettype none

module flag_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_valid,
  input  logic [2:0]  upd_op,
  input  logic [31:0] result,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        shifter_c,
  input  logic [3:0]  msr_nzcv,
  input  logic [3:0]  spsr_nzcv,
  input  logic        stall,
  input  logic        flush,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v,
  output logic [3:0]  nzcv_fwd,
  output logic        mull_pending,
  output logic        seq_err
);

  localparam logic [2:0] OP_ARITH   = 3'b000;
  localparam logic [2:0] OP_LOGIC   = 3'b001;
  localparam logic [2:0] OP_MUL     = 3'b010;
  localparam logic [2:0] OP_MULL_LO = 3'b011;
  localparam logic [2:0] OP_MULL_HI = 3'b100;
  localparam logic [2:0] OP_MSR     = 3'b101;
  localparam logic [2:0] OP_RESTORE = 3'b110;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    LO_SEEN = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] flags;
  logic [3:0] flags_next;
  logic       lo_zero;
  logic       lo_zero_next;
  logic       seq_err_next;
  logic       res_zero;
  logic       accept;

  assign res_zero = (result == 32'h0000_0000);
  assign accept   = upd_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      flags   <= 4'b0000;
      lo_zero <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      state   <= state_next;
      flags   <= flags_next;
      lo_zero <= lo_zero_next;
      seq_err <= seq_err_next;
    end
  end

  always_comb begin
    state_next   = state;
    flags_next   = flags;
    lo_zero_next = lo_zero;
    seq_err_next = 1'b0;
    if (flush) begin
      // A flush abandons any half-finished long multiply but keeps flags.
      state_next = IDLE;
    end else if (accept) begin
      case (upd_op)
        OP_ARITH:   flags_next = {result[31], res_zero, alu_c, alu_v};
        OP_LOGIC:   flags_next = {result[31], res_zero, shifter_c, flags[0]};
        OP_MUL:     flags_next = {result[31], res_zero, flags[1:0]};
        OP_MULL_LO: begin
          lo_zero_next = res_zero;
          state_next   = LO_SEEN;
          seq_err_next = (state == LO_SEEN);
        end
        OP_MULL_HI: begin
          if (state == LO_SEEN) begin
            flags_next = {result[31], lo_zero & res_zero, flags[1:0]};
            state_next = IDLE;
          end else begin
            seq_err_next = 1'b1;
          end
        end
        OP_MSR:     flags_next = msr_nzcv;
        OP_RESTORE: flags_next = spsr_nzcv;
        default:    flags_next = flags;
      endcase
    end
  end

  assign {n, z, c, v}  = flags;
  assign nzcv_fwd      = flags_next;
  assign mull_pending  = (state == LO_SEEN);

endmodule

`default_nettype wire

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed scenario tasks plus a randomized run against a
// behavioural flag model.
`default_nettype none

module tb_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic [2:0]  upd_op;
  logic [31:0] result;
  logic        alu_c, alu_v, shifter_c;
  logic [3:0]  msr_nzcv, spsr_nzcv;
  logic        stall, flush;
  logic        n, z, c, v;
  logic [3:0]  nzcv_fwd;
  logic        mull_pending;
  logic        seq_err;

  int checks   = 0;
  int failures = 0;

  flag_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .upd_valid    (upd_valid),
    .upd_op       (upd_op),
    .result       (result),
    .alu_c        (alu_c),
    .alu_v        (alu_v),
    .shifter_c    (shifter_c),
    .msr_nzcv     (msr_nzcv),
    .spsr_nzcv    (spsr_nzcv),
    .stall        (stall),
    .flush        (flush),
    .n            (n),
    .z            (z),
    .c            (c),
    .v            (v),
    .nzcv_fwd     (nzcv_fwd),
    .mull_pending (mull_pending),
    .seq_err      (seq_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic vld, input logic [2:0] op, input logic [31:0] r,
                       input logic [3:0] msr, input logic st, input logic fl);
    upd_valid = vld; upd_op = op; result = r; msr_nzcv = msr;
    alu_c = 1'b0; alu_v = 1'b0; shifter_c = 1'b0; spsr_nzcv = 4'b0000;
    stall = st; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 4'b0000, 1'b0, 1'b0);
    #2;
    checks++;
    if ({n, z, c, v, mull_pending, seq_err} !== 6'b000000) begin
      failures++;
      $display("FAIL reset_state got=%b exp=000000", {n, z, c, v, mull_pending, seq_err});
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    drive(1'b1, 3'b000, 32'h0, 4'b0000, 1'b0, 1'b0);
    alu_c = 1'b1;
    #1;
    checks++;
    if (nzcv_fwd !== 4'b0110) begin
      failures++;
      $display("FAIL arith_fwd got=%b exp=0110", nzcv_fwd);
    end
    tick();
    checks++;
    if ({n, z, c, v} !== 4'b0110) begin
      failures++;
      $display("FAIL arith_commit got=%b exp=0110", {n, z, c, v});
    end
  endtask

  task automatic test_logic_mul();
    drive(1'b1, 3'b101, 32'h0, 4'b0011, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b001, 32'h8000_0000, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({n, z, c, v} !== 4'b1001) begin
      failures++;
      $display("FAIL logic_keep_v got=%b exp=1001", {n, z, c, v});
    end
    drive(1'b1, 3'b010, 32'h1, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({n, z, c, v} !== 4'b0001) begin
      failures++;
      $display("FAIL mul_keep_cv got=%b exp=0001", {n, z, c, v});
    end
    drive(1'b1, 3'b110, 32'h0, 4'b0000, 1'b0, 1'b0);
    spsr_nzcv = 4'b1100;
    tick();
    checks++;
    if ({n, z, c, v} !== 4'b1100) begin
      failures++;
      $display("FAIL restore got=%b exp=1100", {n, z, c, v});
    end
    drive(1'b1, 3'b111, 32'h0, 4'b0011, 1'b0, 1'b0);
    tick();
    checks++;
    if ({n, z, c, v, seq_err} !== 5'b11000) begin
      failures++;
      $display("FAIL reserved_op got=%b exp=11000", {n, z, c, v, seq_err});
    end
  endtask

  task automatic test_mull();
    drive(1'b1, 3'b101, 32'h0, 4'b1001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b011, 32'h0, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({n, z, c, v, mull_pending} !== 5'b10011) begin
      failures++;
      $display("FAIL mull_lo_pending got=%b exp=10011", {n, z, c, v, mull_pending});
    end
    drive(1'b1, 3'b100, 32'h0, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({n, z, c, v, mull_pending} !== 5'b01010) begin
      failures++;
      $display("FAIL mull_hi_zero got=%b exp=01010", {n, z, c, v, mull_pending});
    end
    drive(1'b1, 3'b011, 32'h5, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b100, 32'h0, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({n, z, c, v, mull_pending} !== 5'b00010) begin
      failures++;
      $display("FAIL mull_lo_nonzero got=%b exp=00010", {n, z, c, v, mull_pending});
    end
    // Unrelated op between LO and HI must not disturb lo_zero or the state.
    drive(1'b1, 3'b011, 32'h0, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b000, 32'h1, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({n, z, c, v, mull_pending} !== 5'b00001) begin
      failures++;
      $display("FAIL mull_interleave got=%b exp=00001", {n, z, c, v, mull_pending});
    end
    drive(1'b1, 3'b100, 32'h0, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({n, z, c, v, mull_pending} !== 5'b01000) begin
      failures++;
      $display("FAIL mull_after_interleave got=%b exp=01000", {n, z, c, v, mull_pending});
    end
  endtask

  task automatic test_seq_err();
    drive(1'b1, 3'b101, 32'h0, 4'b1010, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b100, 32'h0, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({n, z, c, v, mull_pending, seq_err} !== 6'b101001) begin
      failures++;
      $display("FAIL hi_from_idle got=%b exp=101001", {n, z, c, v, mull_pending, seq_err});
    end
    drive(1'b0, 3'b000, 32'h0, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if (seq_err !== 1'b0) begin
      failures++;
      $display("FAIL seq_err_one_cycle got=%b exp=0", seq_err);
    end
    drive(1'b1, 3'b011, 32'h0, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b011, 32'h7, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({mull_pending, seq_err} !== 2'b11) begin
      failures++;
      $display("FAIL lo_twice got=%b exp=11", {mull_pending, seq_err});
    end
    drive(1'b1, 3'b100, 32'h0, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({n, z, c, v, mull_pending, seq_err} !== 6'b001000) begin
      failures++;
      $display("FAIL lo_overwrite got=%b exp=001000", {n, z, c, v, mull_pending, seq_err});
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 3'b101, 32'h0, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b101, 32'h0, 4'b1111, 1'b1, 1'b0);
    #1;
    checks++;
    if (nzcv_fwd !== 4'b0000) begin
      failures++;
      $display("FAIL stall_fwd got=%b exp=0000", nzcv_fwd);
    end
    tick();
    checks++;
    if ({n, z, c, v} !== 4'b0000) begin
      failures++;
      $display("FAIL stall_hold got=%b exp=0000", {n, z, c, v});
    end
    drive(1'b1, 3'b011, 32'h5, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b101, 32'h0, 4'b1111, 1'b1, 1'b1);
    tick();
    checks++;
    if ({n, z, c, v, mull_pending, seq_err} !== 6'b000000) begin
      failures++;
      $display("FAIL flush_in_lo got=%b exp=000000", {n, z, c, v, mull_pending, seq_err});
    end
    drive(1'b1, 3'b100, 32'h0, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if (seq_err !== 1'b1) begin
      failures++;
      $display("FAIL flush_forced_idle got=%b exp=1", seq_err);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 3'b101, 32'h0, 4'b1111, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b011, 32'h3, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'b000, 32'h0, 4'b0000, 1'b0, 1'b0);
    checks++;
    if ({n, z, c, v, mull_pending} !== 5'b11111) begin
      failures++;
      $display("FAIL pre_reset got=%b exp=11111", {n, z, c, v, mull_pending});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({n, z, c, v, mull_pending, seq_err} !== 6'b000000) begin
      failures++;
      $display("FAIL async_reset got=%b exp=000000", {n, z, c, v, mull_pending, seq_err});
    end
    #3;
    rst_n = 1'b1;
    drive(1'b1, 3'b000, 32'h8000_0000, 4'b0000, 1'b0, 1'b0);
    alu_v = 1'b1;
    tick();
    checks++;
    if ({n, z, c, v} !== 4'b1001) begin
      failures++;
      $display("FAIL first_after_reset got=%b exp=1001", {n, z, c, v});
    end
  endtask

  task automatic test_random();
    logic [3:0] m_f, e_f;
    logic       m_p, m_lz, e_p, e_lz, e_e, rz;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_f = 4'b0000; m_p = 1'b0; m_lz = 1'b0;
    for (int i = 0; i < 500; i++) begin
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_op    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) upd_op = 3'(3 + $urandom_range(0, 1));
      result    = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      alu_c = 1'($urandom); alu_v = 1'($urandom); shifter_c = 1'($urandom);
      msr_nzcv = 4'($urandom); spsr_nzcv = 4'($urandom);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      rz = (result == 32'h0);
      e_f = m_f; e_p = m_p; e_lz = m_lz; e_e = 1'b0;
      if (flush) e_p = 1'b0;
      else if (upd_valid && !stall) begin
        case (upd_op)
          3'd0: e_f = {result[31], rz, alu_c, alu_v};
          3'd1: e_f = {result[31], rz, shifter_c, m_f[0]};
          3'd2: e_f = {result[31], rz, m_f[1:0]};
          3'd3: begin e_lz = rz; e_e = m_p; e_p = 1'b1; end
          3'd4: if (m_p) begin e_f = {result[31], m_lz & rz, m_f[1:0]}; e_p = 1'b0; end
                else e_e = 1'b1;
          3'd5: e_f = msr_nzcv;
          3'd6: e_f = spsr_nzcv;
          default: ;
        endcase
      end
      #1;
      checks++;
      if (nzcv_fwd !== e_f) begin
        failures++;
        $display("FAIL rand_fwd[%0d] got=%b exp=%b", i, nzcv_fwd, e_f);
      end
      tick();
      m_f = e_f; m_p = e_p; m_lz = e_lz;
      checks++;
      if ({n, z, c, v, mull_pending, seq_err} !== {e_f, e_p, e_e}) begin
        failures++;
        $display("FAIL rand_state[%0d] got=%b exp=%b", i,
                 {n, z, c, v, mull_pending, seq_err}, {e_f, e_p, e_e});
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic_mul();
    test_mull();
    test_seq_err();
    test_stall_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: upd_valid  in  1  flag update request this cycle.
REQ-004 SHALL have ports: upd_op  in  3  update kind: 000 ARITH, 001 LOGIC, 010 MUL, 011 MULL_LO, 100 MULL_HI, 101 MSR, 110 RESTORE, 111 reserved.
REQ-005 SHALL have ports: result  in  32  ALU/multiplier result word (MULL_LO: low word, MULL_HI: high word).
REQ-006 SHALL have ports: alu_c, alu_v  in  1 each  adder carry-out, overflow; shifter_c  in  1  barrel-shifter carry-out.
REQ-007 SHALL have ports: msr_nzcv, spsr_nzcv  in  4 each  flag fields for MSR and RESTORE, bit order {N,Z,C,V}.
REQ-008 SHALL have ports: stall  in  1  freeze; flush  in  1  discard pipeline work.
REQ-009 SHALL have ports: n, z, c, v  out  1 each  committed flags, registered, consumed by condition evaluation.
REQ-010 SHALL have ports: nzcv_fwd  out  4  combinational next-state flags {N,Z,C,V}; mull_pending  out  1  high in state LO_SEEN; seq_err  out  1  registered one-cycle error pulse.

Function
REQ-011 SHALL commit flags on the rising edge where upd_valid=1, stall=0, flush=0; n/z/c/v show new values the following cycle (latency 1).
REQ-012 ARITH SHALL set N=result[31], Z=(result==0), C=alu_c, V=alu_v.
REQ-013 LOGIC SHALL set N=result[31], Z=(result==0), C=shifter_c; V unchanged.
REQ-014 MUL SHALL set N=result[31], Z=(result==0); C, V unchanged.
REQ-015 MSR SHALL load all four flags from msr_nzcv; RESTORE SHALL load all four from spsr_nzcv.
REQ-016 op 111 SHALL change nothing and raise no error.
REQ-017 State machine SHALL have states IDLE and LO_SEEN, plus a 1-bit lo_zero register.
REQ-018 MULL_LO in IDLE SHALL store lo_zero=(result==0), go to LO_SEEN, leave flags unchanged.
REQ-019 MULL_HI in LO_SEEN SHALL set N=result[31], Z=lo_zero&(result==0), leave C, V unchanged, and go to IDLE.
REQ-020 MULL_HI in IDLE SHALL leave flags unchanged and pulse seq_err for one cycle.
REQ-021 MULL_LO in LO_SEEN SHALL overwrite lo_zero, stay in LO_SEEN, and pulse seq_err.
REQ-022 Any other op in LO_SEEN SHALL commit normally and leave state and lo_zero unchanged.
REQ-023 stall=1 SHALL hold flags, state, lo_zero, and seq_err=0, ignoring upd_valid.
REQ-024 flush=1 SHALL override stall, drop the same-cycle update, force state IDLE, keep flags, and set seq_err=0.
REQ-025 nzcv_fwd SHALL equal the value n/z/c/v will hold after the next edge; it equals current flags when no commit occurs.
REQ-026 Z SHALL be computed over the full 32-bit word; no sign or width extension of result.

Reset
REQ-027 rst_n=0 SHALL asynchronously force n=z=c=v=0, state IDLE, lo_zero=0, seq_err=0, and mull_pending=0.
REQ-028 Deassertion SHALL be sampled synchronously, with the first update accepted on the first rising edge with rst_n=1.
REQ-029 Reset asserted while in LO_SEEN SHALL abandon the pending long multiply with no flag change beyond the reset values.

Verification
REQ-030 ARITH, result=0x00000000, alu_c=1, alu_v=0 -> next cycle nzcv=0110; nzcv_fwd=0110 in the request cycle.
REQ-031 From flags 0011: LOGIC, result=0x80000000, shifter_c=0 -> 1001 (V kept); MUL, result=0x1 -> 0001.
REQ-032 MULL_LO result=0, then MULL_HI result=0 -> Z=1, N=0, mull_pending 1 then 0; repeat with LO=0x5 -> Z=0.
REQ-033 MULL_HI from IDLE -> seq_err=1 for exactly one cycle, flags unchanged; MULL_LO twice -> seq_err pulse, mull_pending stays 1.
REQ-034 MSR 1111 with stall=1 -> flags unchanged; MSR 1111 with stall=1 and flush=1 in LO_SEEN -> flags unchanged, state IDLE.
REQ-035 rst_n pulled low mid-cycle in LO_SEEN with flags 1111 -> immediately nzcv=0000, mull_pending=0, without waiting for clk.
